// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding and default widths for the sweep controller
package sweep_pkg;

   localparam int SWEEP_WIDTH  = 8;
   localparam int SWEEP_NCYC_W = 4;

`ifdef SWEEP_CTRL_DWELL_EN
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_UP       = 3'd1,
      S_DWELL_HI = 3'd2,
      S_DOWN     = 3'd3,
      S_DWELL_LO = 3'd4
   } sweep_state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_UP   = 3'd1,
      S_DOWN = 3'd3
   } sweep_state_t;
`endif

endpackage

// File: rtl/sweep_dwell_timer.sv
// rtl/sweep_dwell_timer.sv - loadable down-counter that flags its last hold cycle
module sweep_dwell_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         enable,
   input  logic [W-1:0] value,
   output logic         expire
);

   logic [W-1:0] timer;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer <= '0;
      end else if (load) begin
         timer <= value;
      end else if (enable && timer != '0) begin
         timer <= timer - 1'b1;
      end
   end

   assign expire = (timer == W'(1));

endmodule

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - triangular up/down sweep between captured bounds with optional bound dwell
// Dwell states and timer are built only when SWEEP_CTRL_DWELL_EN is defined.
module sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int WIDTH  = SWEEP_WIDTH,
   parameter int NCYC_W = SWEEP_NCYC_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [WIDTH-1:0]  lo,
   input  logic [WIDTH-1:0]  hi,
   input  logic [NCYC_W-1:0] ncycles,
   input  logic [NCYC_W-1:0] dwell,
   output logic [WIDTH-1:0]  count,
   output logic              dir,
   output logic              busy,
   output logic              done,
   output logic              err
);

   sweep_state_t      state;
   logic [WIDTH-1:0]  lo_r;
   logic [WIDTH-1:0]  hi_r;
   logic [NCYC_W-1:0] ncyc_r;
   logic [NCYC_W-1:0] sweeps;
   logic [NCYC_W-1:0] sweeps_nxt;
   logic              last_sweep;

   assign sweeps_nxt = sweeps + 1'b1;
   assign last_sweep = (ncyc_r != '0) && (sweeps_nxt == ncyc_r);

`ifdef SWEEP_CTRL_DWELL_EN
   logic [NCYC_W-1:0] dwell_r;
   logic              has_dwell;
   logic              tmr_load;
   logic              tmr_expire;

   assign has_dwell = (dwell_r != '0);
   // Load on the cycle that turns around at a bound so the dwell state sees the full value
   assign tmr_load  = !stop && has_dwell &&
                      ((state == S_UP   && count == hi_r) ||
                       (state == S_DOWN && count == lo_r && !last_sweep));

   sweep_dwell_timer #(.W(NCYC_W)) u_dwell_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (tmr_load),
      .enable (state == S_DWELL_HI || state == S_DWELL_LO),
      .value  (dwell_r),
      .expire (tmr_expire)
   );
`else
   logic unused_dwell;
   assign unused_dwell = ^dwell;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         count  <= '0;
         dir    <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         lo_r   <= '0;
         hi_r   <= '0;
         ncyc_r <= '0;
         sweeps <= '0;
`ifdef SWEEP_CTRL_DWELL_EN
         dwell_r <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (state == S_IDLE) begin
            if (start) begin
               if (lo < hi) begin
                  lo_r   <= lo;
                  hi_r   <= hi;
                  ncyc_r <= ncycles;
`ifdef SWEEP_CTRL_DWELL_EN
                  dwell_r <= dwell;
`endif
                  count  <= lo;
                  dir    <= 1'b1;
                  sweeps <= '0;
                  busy   <= 1'b1;
                  state  <= S_UP;
               end else begin
                  err <= 1'b1;
               end
            end
         end else if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_UP: begin
                  if (count != hi_r) begin
                     count <= count + 1'b1;
                     dir   <= 1'b1;
                  end else begin
                     dir <= 1'b0;
`ifdef SWEEP_CTRL_DWELL_EN
                     state <= has_dwell ? S_DWELL_HI : S_DOWN;
`else
                     state <= S_DOWN;
`endif
                  end
               end
               S_DOWN: begin
                  if (count != lo_r) begin
                     count <= count - 1'b1;
                     dir   <= 1'b0;
                  end else begin
                     sweeps <= sweeps_nxt;
                     if (last_sweep) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        dir <= 1'b1;
`ifdef SWEEP_CTRL_DWELL_EN
                        state <= has_dwell ? S_DWELL_LO : S_UP;
`else
                        state <= S_UP;
`endif
                     end
                  end
               end
`ifdef SWEEP_CTRL_DWELL_EN
               S_DWELL_HI: if (tmr_expire) state <= S_DOWN;
               S_DWELL_LO: if (tmr_expire) state <= S_UP;
`endif
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
